// File: rtl/argmax_pkg.sv
// argmax_pkg
//   Shared parameters and types for the argmax_6_16 streaming argmax stage.
//   M  : elements per vector
//   T  : element width (signed two's complement)
//   IW : index width, wide enough for 0..M-1
package argmax_pkg;
   localparam int M  = 6;
   localparam int T  = 16;
   localparam int IW = $clog2(M);

   typedef logic signed [T-1:0] elem_t;
   typedef logic [IW-1:0]       idx_t;
endpackage : argmax_pkg

// File: rtl/argmax_hold.sv
// argmax_hold
//   Output holding register for the argmax stage. It captures the winner of a
//   completed vector, keeps it stable until the downstream drains it, and
//   produces the ingress stall term.
//   Optional feature macro: ARGMAX_EMIT_MAX_EN (adds the held maximum value).
//
// Ports
//   clk, reset : clock, asynchronous active-high reset
//   load       : final element of a vector is being accepted this cycle
//   last       : element counter points at the final element of a vector
//   m_ready    : downstream accepts the held result
//   win_idx    : winning index to capture on load
//   win_val    : winning value to capture on load (ARGMAX_EMIT_MAX_EN only)
//   s_ready    : upstream element may be accepted
//   m_valid    : held result is valid
//   idx_out    : held winning index
//   max_out    : held winning value (ARGMAX_EMIT_MAX_EN only)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends combinationally on ready, and ready here depends
// only on registered state and m_ready.
module argmax_hold
   import argmax_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  load,
   input  logic  last,
   input  logic  m_ready,
   input  idx_t  win_idx,
`ifdef ARGMAX_EMIT_MAX_EN
   input  elem_t win_val,
   output elem_t max_out,
`endif
   output logic  s_ready,
   output logic  m_valid,
   output idx_t  idx_out
);

   logic out_full;

   // Only the final element of a vector has to wait for an undrained result;
   // earlier elements only touch the running compare registers.
   assign s_ready = !(last && out_full && !m_ready);
   assign m_valid = out_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_full <= 1'b0;
         idx_out  <= '0;
`ifdef ARGMAX_EMIT_MAX_EN
         max_out  <= '0;
`endif
      end else begin
         // A load in the same cycle as a drain keeps the flag set and simply
         // replaces the result, so back-to-back vectors see no bubble.
         if (load) begin
            out_full <= 1'b1;
            idx_out  <= win_idx;
`ifdef ARGMAX_EMIT_MAX_EN
            max_out  <= win_val;
`endif
         end else if (out_full && m_ready) begin
            out_full <= 1'b0;
         end
      end
   end

endmodule : argmax_hold

// File: rtl/argmax_6_16.sv
// argmax_6_16
//   Streaming argmax over vectors of M signed T-bit elements. Each vector of
//   M consecutive accepted elements yields one result: the index of the
//   largest element (earliest index wins ties), plus optionally its value.
//   Optional feature macro: ARGMAX_EMIT_MAX_EN (adds the max_out port).
//
// Ports
//   clk, reset : clock, asynchronous active-high reset
//   s_valid    : upstream element valid
//   s_ready    : this block accepts an element
//   data_in    : signed element
//   m_valid    : result valid
//   m_ready    : downstream accepts result
//   idx_out    : index of the maximum element
//   max_out    : maximum value (ARGMAX_EMIT_MAX_EN only)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends combinationally on ready, and ready here depends
// only on registered state and m_ready.
module argmax_6_16
   import argmax_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  s_valid,
   output logic  s_ready,
   input  elem_t data_in,
   output logic  m_valid,
   input  logic  m_ready,
`ifdef ARGMAX_EMIT_MAX_EN
   output elem_t max_out,
`endif
   output idx_t  idx_out
);

   idx_t  cnt;
   elem_t best_val;
   idx_t  best_idx;
   elem_t cand_val;
   idx_t  cand_idx;
   logic  last;
   logic  accept;

   assign last   = (cnt == IW'(M - 1));
   assign accept = s_valid && s_ready;

   // Candidate winner including the element on data_in. Element 0 seeds the
   // compare so no artificial baseline biases all-negative vectors.
   always_comb begin
      cand_val = best_val;
      cand_idx = best_idx;
      if (cnt == '0) begin
         cand_val = data_in;
         cand_idx = '0;
      end else if (data_in > best_val) begin
         cand_val = data_in;
         cand_idx = cnt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         best_val <= '0;
         best_idx <= '0;
      end else if (accept) begin
         best_val <= cand_val;
         best_idx <= cand_idx;
         cnt      <= last ? '0 : cnt + 1'b1;
      end
   end

   argmax_hold u_hold (
      .clk     (clk),
      .reset   (reset),
      .load    (accept && last),
      .last    (last),
      .m_ready (m_ready),
      .win_idx (cand_idx),
`ifdef ARGMAX_EMIT_MAX_EN
      .win_val (cand_val),
      .max_out (max_out),
`endif
      .s_ready (s_ready),
      .m_valid (m_valid),
      .idx_out (idx_out)
   );

endmodule : argmax_6_16

// File: tb/tb_argmax_6_16.sv
module tb_argmax_6_16;
   import argmax_pkg::*;

   typedef elem_t vec_t [6];

   logic  clk;
   logic  reset;
   logic  s_valid;
   logic  s_ready;
   elem_t data_in;
   logic  m_valid;
   logic  m_ready;
   idx_t  idx_out;
`ifdef ARGMAX_EMIT_MAX_EN
   elem_t max_out;
`endif

   int total;
   int bad;

   // Results observed leaving the DUT, in order.
   logic [IW-1:0] got_q[$];
   // Expected results for the random scenario.
   logic [IW-1:0] exp_q[$];

   argmax_6_16 dut (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .data_in (data_in),
      .m_valid (m_valid),
      .m_ready (m_ready),
`ifdef ARGMAX_EMIT_MAX_EN
      .max_out (max_out),
`endif
      .idx_out (idx_out)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change at posedge+1; the monitor samples at negedge.
   always @(negedge clk) begin
      if (!reset && m_valid && m_ready) got_q.push_back(idx_out);
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_elem(input elem_t v);
      int n;
      n = 0;
      s_valid = 1'b1;
      data_in = v;
      @(negedge clk);
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!s_ready) begin
         bad++;
         $display("FAIL send_elem_timeout: s_ready=%0b required 1 within 50 cycles", s_ready);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      data_in = 'x;
   endtask

   task automatic send_vec(input vec_t v);
      for (int i = 0; i < 6; i++) send_elem(v[i]);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset   = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b0;
      data_in = 'x;
      idle(3);
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
      total++;
      if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
      total++;
      if (idx_out !== 3'd0) begin bad++; $display("FAIL reset_idx_out: got %0d want 0", idx_out); end
      @(negedge clk);
      reset = 1'b0;
      idle(1);
   endtask

   task automatic test_tie;
      int base;
      base = got_q.size();
      m_ready = 1'b1;
      send_vec('{16'sd3, -16'sd1, 16'sd7, 16'sd7, 16'sd2, 16'sd0});
      total++;
      if (m_valid !== 1'b1 || idx_out !== 3'd2) begin
         bad++;
         $display("FAIL tie_latency: m_valid=%0b idx=%0d want m_valid=1 idx=2", m_valid, idx_out);
      end
`ifdef ARGMAX_EMIT_MAX_EN
      total++;
      if (max_out !== 16'sd7) begin bad++; $display("FAIL tie_max: got %0d want 7", max_out); end
`endif
      idle(1);
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL tie_one_cycle: m_valid=%0b want 0", m_valid); end
      idle(2);
      total++;
      if (got_q.size() - base != 1 || got_q[base] !== 3'd2) begin
         bad++;
         $display("FAIL tie_result: count=%0d want 1, idx want 2", got_q.size() - base);
      end
   endtask

   task automatic test_signed;
      int base;
      base = got_q.size();
      m_ready = 1'b1;
      send_vec('{-16'sd5, -16'sd3, -16'sd9, -16'sd4, -16'sd8, -16'sd6});
      total++;
      if (m_valid !== 1'b1 || idx_out !== 3'd1) begin
         bad++;
         $display("FAIL signed_idx: m_valid=%0b idx=%0d want 1/1", m_valid, idx_out);
      end
`ifdef ARGMAX_EMIT_MAX_EN
      total++;
      if (max_out !== -16'sd3) begin bad++; $display("FAIL signed_max: got %0d want -3", max_out); end
`endif
      idle(3);
      total++;
      if (got_q.size() - base != 1 || got_q[base] !== 3'd1) begin
         bad++;
         $display("FAIL signed_result: count=%0d want 1", got_q.size() - base);
      end
   endtask

   task automatic test_back_to_back_extremes;
      int base;
      base = got_q.size();
      m_ready = 1'b1;
      send_vec('{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 16'sd32767});
      total++;
      if (idx_out !== 3'd5) begin bad++; $display("FAIL extreme_a: idx=%0d want 5", idx_out); end
      send_vec('{16'sd32767, -16'sd32768, 16'sd0, 16'sd0, 16'sd0, 16'sd32767});
      total++;
      if (m_valid !== 1'b1 || idx_out !== 3'd0) begin
         bad++;
         $display("FAIL extreme_b: m_valid=%0b idx=%0d want 1/0", m_valid, idx_out);
      end
      idle(3);
      total++;
      if (got_q.size() - base != 2 || got_q[base] !== 3'd5 || got_q[base+1] !== 3'd0) begin
         bad++;
         $display("FAIL extreme_seq: count=%0d want 2 results 5,0", got_q.size() - base);
      end
   endtask

   task automatic test_backpressure;
      int base;
      vec_t v2;
      base = got_q.size();
      v2 = '{16'sd5, 16'sd4, 16'sd3, 16'sd2, 16'sd1, 16'sd8};
      m_ready = 1'b1;
      send_vec('{16'sd0, 16'sd9, 16'sd1, 16'sd2, 16'sd3, 16'sd4});
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         data_in = v2[i];
         @(negedge clk);
         total++;
         if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_%0d: s_ready=%0b want 1", i, s_ready); end
         @(posedge clk);
         #1;
      end
      data_in = v2[5];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (s_ready !== 1'b0 || m_valid !== 1'b1 || idx_out !== 3'd1) begin
            bad++;
            $display("FAIL bp_stall_%0d: s_ready=%0b m_valid=%0b idx=%0d want 0/1/1",
                     i, s_ready, m_valid, idx_out);
         end
         @(posedge clk);
         #1;
      end
      m_ready = 1'b1;
      @(negedge clk);
      total++;
      if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_release: s_ready=%0b want 1", s_ready); end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      data_in = 'x;
      total++;
      if (m_valid !== 1'b1 || idx_out !== 3'd5) begin
         bad++;
         $display("FAIL bp_second: m_valid=%0b idx=%0d want 1/5", m_valid, idx_out);
      end
      idle(3);
      total++;
      if (got_q.size() - base != 2 || got_q[base] !== 3'd1 || got_q[base+1] !== 3'd5) begin
         bad++;
         $display("FAIL bp_seq: count=%0d want 2 results 1,5", got_q.size() - base);
      end
   endtask

   task automatic test_mid_reset;
      int base;
      m_ready = 1'b0;
      send_vec('{16'sd0, 16'sd0, 16'sd0, 16'sd9, 16'sd0, 16'sd0});
      send_elem(16'sd100);
      send_elem(16'sd200);
      send_elem(16'sd300);
      #3;
      reset = 1'b1;
      #1;
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || idx_out !== 3'd0) begin
         bad++;
         $display("FAIL mid_reset_state: m_valid=%0b s_ready=%0b idx=%0d want 0/1/0",
                  m_valid, s_ready, idx_out);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      base = got_q.size();
      m_ready = 1'b1;
      send_vec('{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6});
      idle(3);
      total++;
      if (got_q.size() - base != 1 || got_q[base] !== 3'd5) begin
         bad++;
         $display("FAIL mid_reset_result: count=%0d want 1 result 5", got_q.size() - base);
      end
   endtask

   task automatic test_random;
      int   base, e, vi, cyc, bi, n;
      logic acc;
      vec_t cur;
      base = got_q.size();
      exp_q.delete();
      e = 0; vi = 0; cyc = 0; n = 150;
      for (int j = 0; j < 6; j++) cur[j] = elem_t'(int'($urandom_range(0, 7)) - 4);
      bi = 0;
      for (int j = 1; j < 6; j++) if (cur[j] > cur[bi]) bi = j;
      exp_q.push_back(IW'(bi));
      while (vi < n && cyc < 20000) begin
         m_ready = 1'($urandom_range(0, 1));
         if (!s_valid && $urandom_range(0, 1) == 1) begin
            s_valid = 1'b1;
            data_in = cur[e];
         end
         @(negedge clk);
         acc = s_valid && s_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            s_valid = 1'b0;
            data_in = 'x;
            e++;
            if (e == 6) begin
               e = 0;
               vi++;
               if (vi < n) begin
                  for (int j = 0; j < 6; j++) cur[j] = elem_t'(int'($urandom_range(0, 7)) - 4);
                  bi = 0;
                  for (int j = 1; j < 6; j++) if (cur[j] > cur[bi]) bi = j;
                  exp_q.push_back(IW'(bi));
               end
            end
         end
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      idle(10);
      total++;
      if (got_q.size() - base != exp_q.size()) begin
         bad++;
         $display("FAIL random_count: got %0d results want %0d", got_q.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
         total++;
         if (got_q[base+i] !== exp_q[i]) begin
            bad++;
            $display("FAIL random_idx_%0d: got %0d want %0d", i, got_q[base+i], exp_q[i]);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_tie();
      test_signed();
      test_back_to_back_extremes();
      test_backpressure();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_argmax_6_16
